tmds_channel_decoder: RTL and testbench

- Receive-side counterpart of the per-channel TMDS encoder in the hdmi transmitter; one instance per TMDS data channel.
- Takes unaligned 10-bit parallel words from an external 1:10 deserializer (bit 0 = first on wire) and finds the symbol boundary by searching for control tokens.
- Outputs the aligned symbol, decoded video byte, control bits, TERC4 nibble and lock status to a downstream HDMI sink/packet parser.

---
 rtl/tmds_pkg.sv | 55 +++++
 rtl/tmds_symbol_classify.sv | 36 +++
 rtl/tmds_channel_decoder.sv | 170 +++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS symbol tables, alignment state encoding and the video-period decode helper.
// The transmit-side encoder pulls the same tables from here.
package tmds_pkg;

    localparam int unsigned SYM_W   = 10;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CTRL_W  = 2;
    localparam int unsigned TERC4_W = 4;
    localparam int unsigned OFS_W   = 4;

    // Entry index is the {C1,C0} value carried by the token (bit9..bit0 shown).
    localparam logic [SYM_W-1:0] CTRL_TOKEN [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    // Entry index is the TERC4 nibble carried by the code.
    localparam logic [SYM_W-1:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    typedef struct packed {
        logic [SYM_W-1:0]   symbol;
        logic [BYTE_W-1:0]  data;
        logic [CTRL_W-1:0]  ctrl;
        logic [TERC4_W-1:0] terc4;
        logic               is_ctrl;
        logic               is_terc4;
    } tmds_sym_t;

    // Undo the conditional inversion, then the XOR/XNOR transition chain.
    function automatic logic [BYTE_W-1:0] tmds_decode_video(input logic [SYM_W-1:0] q);
        logic [BYTE_W-1:0] b;
        logic [BYTE_W-1:0] d;
        b    = q[9] ? ~q[7:0] : q[7:0];
        d    = '0;
        d[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_symbol_classify.sv
// Combinational classification of one aligned 10-bit TMDS symbol into its
// control, TERC4 and video interpretations; all three are produced in parallel.
module tmds_symbol_classify
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0]   symbol,
    output logic [BYTE_W-1:0]  data_c,
    output logic [CTRL_W-1:0]  ctrl_c,
    output logic [TERC4_W-1:0] terc4_c,
    output logic               is_ctrl_c,
    output logic               is_terc4_c
);

    assign data_c = tmds_decode_video(symbol);

    // Tables are disjoint within themselves, so at most one entry of each matches.
    always_comb begin
        is_ctrl_c  = 1'b0;
        ctrl_c     = '0;
        is_terc4_c = 1'b0;
        terc4_c    = '0;
        for (int i = 0; i < 4; i++) begin
            if (symbol == CTRL_TOKEN[i]) begin
                is_ctrl_c = 1'b1;
                ctrl_c    = CTRL_W'(i);
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (symbol == TERC4_CODE[i]) begin
                is_terc4_c = 1'b1;
                terc4_c    = TERC4_W'(i);
            end
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// Per-channel TMDS receiver: finds the symbol boundary in the deserialized stream
// by hunting for control-token runs, then registers the aligned symbol and its decodes.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned CTRL_RUN     = 8,
    parameter int unsigned LOCK_TIMEOUT = 2048
) (
    input  logic               clk_pixel,
    input  logic               reset,
    input  logic [SYM_W-1:0]   tmds_raw,
    output logic [SYM_W-1:0]   symbol,
    output logic [BYTE_W-1:0]  data,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [TERC4_W-1:0] terc4,
    output logic               is_ctrl,
    output logic               is_terc4,
    output logic               locked,
    output logic [OFS_W-1:0]   offset
);

    localparam int unsigned RUN_W = $clog2(CTRL_RUN + 1);
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [OFS_W-1:0] OFS_LAST  = OFS_W'(SYM_W - 1);
    localparam logic [1:0]       ST_SEARCH = 2'(SEARCH);
    localparam logic [1:0]       ST_VERIFY = 2'(VERIFY);
    localparam logic [1:0]       ST_LOCKED = 2'(LOCKED);

    logic [SYM_W-1:0]   raw_q;
    logic [SYM_W-1:0]   aligned_q;
    logic [2*SYM_W-1:0] window_c;

    logic [BYTE_W-1:0]  data_c;
    logic [CTRL_W-1:0]  ctrl_c;
    logic [TERC4_W-1:0] terc4_c;
    logic               is_ctrl_c;
    logic               is_terc4_c;
    tmds_sym_t          dec_c;
    tmds_sym_t          dec_q;

    logic [1:0]       state_q,  state_d;
    logic [OFS_W-1:0] offset_q, offset_d;
    logic [OFS_W-1:0] offset_inc_c;
    logic [RUN_W-1:0] run_q,    run_d;
    logic [TMO_W-1:0] tmo_q,    tmo_d;
    logic             settle_q, settle_d;
    logic             locked_q, locked_d;

    assign window_c = {tmds_raw, raw_q};

    tmds_symbol_classify u_classify (
        .symbol     (aligned_q),
        .data_c     (data_c),
        .ctrl_c     (ctrl_c),
        .terc4_c    (terc4_c),
        .is_ctrl_c  (is_ctrl_c),
        .is_terc4_c (is_terc4_c)
    );

    always_comb begin
        dec_c          = '0;
        dec_c.symbol   = aligned_q;
        dec_c.data     = data_c;
        dec_c.ctrl     = ctrl_c;
        dec_c.terc4    = terc4_c;
        dec_c.is_ctrl  = is_ctrl_c;
        dec_c.is_terc4 = is_terc4_c;
    end

    // Boundary pipeline and decode register; these run regardless of lock.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            raw_q     <= '0;
            aligned_q <= '0;
            dec_q     <= '0;
        end else begin
            raw_q     <= tmds_raw;
            aligned_q <= SYM_W'(window_c >> offset_q);
            dec_q     <= dec_c;
        end
    end

    assign offset_inc_c = (offset_q == OFS_LAST) ? '0 : OFS_W'(offset_q + OFS_W'(1));

    // aligned_q lags offset by one edge, so the word after a slip is skipped (settle).
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        run_d    = run_q;
        tmo_d    = tmo_q;
        settle_d = 1'b0;
        locked_d = locked_q;
        if (!settle_q) begin
            case (state_q)
                ST_SEARCH: begin
                    if (is_ctrl_c) begin
                        state_d = ST_VERIFY;
                        run_d   = RUN_W'(1);
                    end else begin
                        offset_d = offset_inc_c;
                        settle_d = 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (is_ctrl_c) begin
                        if (run_q == RUN_W'(CTRL_RUN - 1)) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            run_d    = '0;
                            tmo_d    = '0;
                        end else begin
                            run_d = RUN_W'(run_q + RUN_W'(1));
                        end
                    end else begin
                        state_d  = ST_SEARCH;
                        run_d    = '0;
                        offset_d = offset_inc_c;
                        settle_d = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (is_ctrl_c) begin
                        tmo_d = '0;
                    end else if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
                        state_d  = ST_SEARCH;
                        locked_d = 1'b0;
                        tmo_d    = '0;
                    end else begin
                        tmo_d = TMO_W'(tmo_q + TMO_W'(1));
                    end
                end
                default: begin
                    state_d  = ST_SEARCH;
                    run_d    = '0;
                    tmo_d    = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q  <= ST_SEARCH;
            offset_q <= '0;
            run_q    <= '0;
            tmo_q    <= '0;
            settle_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            run_q    <= run_d;
            tmo_q    <= tmo_d;
            settle_q <= settle_d;
            locked_q <= locked_d;
        end
    end

    assign symbol   = dec_q.symbol;
    assign data     = dec_q.data;
    assign ctrl     = dec_q.ctrl;
    assign terc4    = dec_q.terc4;
    assign is_ctrl  = dec_q.is_ctrl;
    assign is_terc4 = dec_q.is_terc4;
    assign locked   = locked_q;
    assign offset   = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: directed scenarios plus randomized
// token/TERC4/noise traffic, compared cycle by cycle against a behavioural model.
module tb_tmds_channel_decoder;

    localparam int unsigned CTRL_RUN     = 8;
    localparam int unsigned LOCK_TIMEOUT = 2048;

    localparam logic [9:0] REF_CTRL [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };
    localparam logic [9:0] REF_TERC4 [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] VID0 = 10'h100;

    logic       clk_pixel;
    logic       reset;
    logic [9:0] tmds_raw;
    logic [9:0] symbol;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [3:0] terc4;
    logic       is_ctrl;
    logic       is_terc4;
    logic       locked;
    logic [3:0] offset;

    tmds_channel_decoder #(
        .CTRL_RUN     (CTRL_RUN),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .tmds_raw  (tmds_raw),
        .symbol    (symbol),
        .data      (data),
        .ctrl      (ctrl),
        .terc4     (terc4),
        .is_ctrl   (is_ctrl),
        .is_terc4  (is_terc4),
        .locked    (locked),
        .offset    (offset)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    int         n_vec   = 0;
    int         n_err   = 0;
    int         cyc     = 0;
    int         slip    = 0;
    logic [9:0] tx_prev = '0;

    // Reference model state: wire history, pending aligned word, expected outputs, tracker.
    logic [9:0] m_raw, m_aligned, m_sym;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;
    logic [3:0] m_terc4;
    logic       m_isc, m_ist, m_locked, m_skip;
    int         m_off, m_run, m_idle;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int find_ctrl(input logic [9:0] s);
        find_ctrl = -1;
        for (int i = 0; i < 4; i++) if (REF_CTRL[i] == s) find_ctrl = i;
    endfunction

    function automatic int find_terc4(input logic [9:0] s);
        find_terc4 = -1;
        for (int i = 0; i < 16; i++) if (REF_TERC4[i] == s) find_terc4 = i;
    endfunction

    // d[i] = b[i]^b[i-1] (d0 = b0), with bits 7:1 complemented for XNOR-coded symbols.
    function automatic logic [7:0] ref_video(input logic [9:0] q);
        logic [7:0] b;
        b = q[9] ? ~q[7:0] : q[7:0];
        ref_video = b ^ {b[6:0], 1'b0};
        if (!q[8]) ref_video = ref_video ^ 8'hFE;
    endfunction

    task automatic model_edge(input logic [9:0] w, input logic r);
        logic [9:0] cur;
        logic [19:0] win;
        int c, t;
        if (r) begin
            m_raw = '0; m_aligned = '0; m_sym = '0; m_data = '0; m_ctrl = '0; m_terc4 = '0;
            m_isc = 0; m_ist = 0; m_locked = 0; m_skip = 0; m_off = 0; m_run = 0; m_idle = 0;
            return;
        end
        cur     = m_aligned;
        c       = find_ctrl(cur);
        t       = find_terc4(cur);
        m_sym   = cur;
        m_data  = ref_video(cur);
        m_isc   = (c >= 0);
        m_ist   = (t >= 0);
        m_ctrl  = m_isc ? 2'(c) : 2'b00;
        m_terc4 = m_ist ? 4'(t) : 4'h0;
        win       = {w, m_raw};
        m_aligned = 10'(win >> m_off);
        m_raw     = w;
        if (m_skip) begin
            m_skip = 0;
        end else if (m_locked) begin
            if (c >= 0) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == int'(LOCK_TIMEOUT)) begin
                    m_locked = 0;
                    m_idle   = 0;
                end
            end
        end else if (c >= 0) begin
            m_run++;
            if (m_run == int'(CTRL_RUN)) begin
                m_locked = 1;
                m_run    = 0;
                m_idle   = 0;
            end
        end else begin
            m_run  = 0;
            m_off  = (m_off + 1) % 10;
            m_skip = 1;
        end
    endtask

    task automatic compare_outputs();
        logic [30:0] got, exp;
        got = {symbol, data, is_ctrl ? ctrl : 2'b00, is_terc4 ? terc4 : 4'h0,
               is_ctrl, is_terc4, locked, offset};
        exp = {m_sym, m_data, m_ctrl, m_terc4, m_isc, m_ist, m_locked, 4'(m_off)};
        check_val("outputs", 32'(got), 32'(exp));
    endtask

    task automatic tick(input logic [9:0] w, input logic r);
        reset    = r;
        tmds_raw = w;
        @(posedge clk_pixel);
        model_edge(w, r);
        #1;
        cyc++;
        compare_outputs();
    endtask

    // Transmit one symbol on a wire whose word boundary is displaced by 'slip' bits.
    task automatic send(input logic [9:0] sym);
        logic [19:0] pair;
        pair = {sym, tx_prev};
        tx_prev = sym;
        tick(10'(pair >> (10 - slip)), 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) tick(10'($urandom), 1'b1);
    endtask

    // From reset: lock must rise exactly 9 edges after the offset lands on the true slip.
    task automatic acquire(input int s, input string tag);
        int last_chg, rise, prev_off, got_lock;
        slip = s; last_chg = cyc; prev_off = int'(offset); got_lock = 0; rise = 0;
        for (int i = 0; i < 200 && got_lock == 0; i++) begin
            send(TOK0);
            if (int'(offset) != prev_off) begin
                last_chg = cyc;
                prev_off = int'(offset);
            end
            if (locked) begin
                got_lock = 1;
                rise     = cyc;
            end
        end
        check_val({tag, "_locked"}, 32'(got_lock), 32'd1);
        check_val({tag, "_offset"}, 32'(offset), 32'(s));
        check_val({tag, "_latency"}, 32'(rise - last_chg), 32'd9);
    endtask

    initial begin
        int s, found, r;
        reset    = 1'b1;
        tmds_raw = '0;

        for (int i = 0; i < 3; i++) begin
            tick(10'($urandom), 1'b1);
            check_val("reset_outs",
                      32'({symbol, data, ctrl, terc4, is_ctrl, is_terc4, locked, offset}), 32'd0);
        end
        tick(10'($urandom), 1'b0);
        check_val("post_reset_symbol", 32'(symbol), 32'h000);
        check_val("post_reset_data", 32'(data), 32'h0FE);
        check_val("post_reset_locked", 32'(locked), 32'd0);

        do_reset(2);
        tx_prev = TOK0;
        acquire(3, "slip3");
        check_val("slip3_ctrl", 32'({is_ctrl, ctrl}), 32'b100);

        // One video word after 5 verified tokens drops back to search at offset+1.
        do_reset(2);
        tx_prev = TOK0; slip = 3; found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            send(TOK0);
            if (m_run == 3) found = 1;
        end
        check_val("abort_reach_run3", 32'(found), 32'd1);
        send(VID0); send(TOK0); send(TOK0);
        check_val("abort_offset", 32'(offset), 32'd4);
        check_val("abort_locked", 32'(locked), 32'd0);
        send(TOK0);
        check_val("abort_settle_offset", 32'(offset), 32'd4);
        send(TOK0);
        check_val("abort_resume_offset", 32'(offset), 32'd5);

        do_reset(2);
        tx_prev = TOK0;
        s = $urandom_range(0, 9);
        acquire(s, "lock_a");
        send(VID0); send(10'h2FF);
        send(REF_TERC4[0]);
        check_val("video_100", 32'(data), 32'h00);
        send(REF_TERC4[15]);
        check_val("video_2ff", 32'(data), 32'hFE);
        send(TOK0);
        check_val("terc4_0", 32'({is_terc4, terc4}), 32'h10);
        send(TOK0);
        check_val("terc4_f", 32'({is_terc4, terc4}), 32'h1F);
        check_val("decode_locked", 32'(locked), 32'd1);

        // A single token at word 2047 restarts the idle count.
        repeat (3) send(TOK0);
        for (int i = 1; i <= 2052; i++) begin
            send((i == 2047) ? TOK0 : VID0);
            if (i >= 2049) check_val("rescue_locked", 32'(locked), 32'd1);
        end

        repeat (3) send(TOK0);
        for (int i = 1; i <= 2050; i++) begin
            send(VID0);
            if (i == 2049) check_val("timeout_2047_locked", 32'(locked), 32'd1);
            if (i == 2050) begin
                check_val("timeout_2048_locked", 32'(locked), 32'd0);
                check_val("timeout_offset", 32'(offset), 32'(s));
            end
        end

        do_reset(2);
        tx_prev = TOK0; slip = $urandom_range(0, 9); found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            send(TOK0);
            if (m_run == 6) found = 1;
        end
        check_val("midop_reach_run6", 32'(found), 32'd1);
        tick(10'($urandom), 1'b1);
        check_val("midop_offset", 32'(offset), 32'd0);
        check_val("midop_locked", 32'(locked), 32'd0);
        check_val("midop_symbol", 32'(symbol), 32'd0);
        acquire(slip, "relock");

        // Mixed traffic with occasional slips, noise and resets.
        do_reset(2);
        slip = $urandom_range(0, 9);
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) tick(10'($urandom), 1'b1);
            else if (r == 1) begin
                slip = $urandom_range(0, 9);
                send(REF_CTRL[$urandom_range(0, 3)]);
            end else if (r < 140) send(REF_CTRL[$urandom_range(0, 3)]);
            else if (r < 175) send(REF_TERC4[$urandom_range(0, 15)]);
            else send(10'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
